immediate_encoder: RTL
======================

Name: immediate_encoder

Overview:
- Inverse of the ID-stage immediate decode: scatters a 32-bit immediate into the I/S/B/U/J bit positions of a RISC-V instruction word.
- Non-immediate fields (opcode, rd, rs1, rs2, funct3, funct7) come from a caller-supplied base word.
- Used by the boot/self-test instruction builder and the verification model.
- 2-stage valid/ready pipeline, throughput 1 instr/cycle.
- Range/alignment checks, plus encoded and error counters.

Parameters:
- CNT_WIDTH, 16, width of the saturating statistics counters.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  reset; asynchronous assert, active-low.
- in_valid_i  input  1  request valid.
- in_ready_o  output  1  request accepted when in_valid_i && in_ready_o.
- base_instr_i  input  DATA_WIDTH  instruction with non-immediate fields set; immediate bit positions are ignored.
- immediate_i  input  DATA_WIDTH  immediate value, two's complement.
- ImmSel_i  input  imm_sel_e  format: IMM_ITYPE/STYPE/BTYPE/UTYPE/JTYPE.
- out_valid_o  output  1  encoded result valid.
- out_ready_i  input  1  consumer ready.
- instruction_o  output  DATA_WIDTH  encoded instruction.
- imm_err_o  output  1  immediate illegal for the selected format; qualified by out_valid_o.
- enc_count_o  output  CNT_WIDTH  results delivered, saturating.
- err_count_o  output  CNT_WIDTH  delivered results with imm_err_o=1, saturating.

Behaviour:
- Reset (async, rst_n_i=0):
  - S1/S2 valid bits cleared.
  - out_valid_o=0, instruction_o=0, imm_err_o=0.
  - Both counters=0.
  - Reset mid-operation discards in-flight entries; nothing is emitted after release until new input.
- Pipeline:
  - S1 registers the accepted request.
  - S2 holds the encoded word and error bit and drives the outputs.
  - s2_en = !s2_valid || out_ready_i; s1_en = !s1_valid || s2_en; in_ready_o = s1_en.
  - Latency: accept at edge N → out_valid_o=1 after edge N+1.
  - Outputs stay stable while out_valid_o && !out_ready_i.
  - No drops, no duplicates; order preserved.
  - Simultaneous accept and emit in the same cycle is allowed (full throughput).
- Encoding: bits not listed below are copied from base_instr_i.
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5]; [11:7]=imm[4:0].
  - B: [31]=imm[12]; [7]=imm[11]; [30:25]=imm[10:5]; [11:8]=imm[4:1].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20]; [30:21]=imm[10:1]; [20]=imm[11]; [19:12]=imm[19:12].
  - Any other ImmSel_i: instruction_o=base_instr_i and imm_err_o=1.
- Error rules (computed in S1, registered into S2):
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0]≠0.
  - An erroneous result is still emitted, with the truncated encoding.
- Round-trip invariant: when imm_err_o=0, decoding instruction_o with the same ImmSel returns immediate_i exactly.
- Counters:
  - Increment on out_valid_o && out_ready_i; err_count_o increments only when imm_err_o=1 as well.
  - Each counter saturates at all-ones with no wrap.

Test Plan:
- Reset release, in_valid_i=0 → out_valid_o=0, instruction_o=0, both counters 0, in_ready_o=1.
- I, base 0x00000513, imm 0xFFFFFFFF → 0xFFF00513, err 0, out_valid_o asserted 2 cycles after accept.
- B, base 0x00000063, imm 0xFFFFF000 → 0x80000063; J, base 0x0000006F, imm 0x00000800 → 0x0010006F; U, base 0x00000537, imm 0x12345000 → 0x12345537; all err 0.
- Errors:
  - S, imm 0x00000800 → err 1.
  - J, imm 0x00000003 → err 1.
  - U, imm 0x00000001 → err 1.
  - Expected after these three: err_count_o=3.
- Backpressure:
  - Stream 8 back-to-back requests with out_ready_i toggling 1,0,0,1…
  - All 8 appear in order with stable outputs during stalls.
  - in_ready_o drops only when S1 and S2 are both full and stalled.
  - enc_count_o=8.
- Random round-trip, 10k requests of legal immediates per format → decoded(instruction_o)==immediate_i. Then assert rst_n_i mid-stream → no further outputs and counters 0.

Source files
------------

// File: rtl/immediate_encoder.sv
// ---------------------------------------------------------------------------
// immediate_encoder
//
// Scatters a 32-bit two's-complement immediate into the I/S/B/U/J immediate
// bit positions of a RISC-V instruction word (the inverse of the ID-stage
// immediate decode). All non-immediate fields are taken from a caller-supplied
// base word. Two-stage valid/ready pipeline with full throughput, a legality
// check on the immediate for the selected format, and saturating counters of
// delivered results and delivered errors.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_n_i        asynchronous active-low reset
//   in_valid_i     request valid
//   in_ready_o     request accepted when in_valid_i && in_ready_o
//   base_instr_i   instruction with the non-immediate fields already set
//   immediate_i    immediate value (two's complement)
//   ImmSel_i       format select: 0=I, 1=S, 2=B, 3=U, 4=J; other codes illegal
//   out_valid_o    encoded result valid
//   out_ready_i    consumer ready
//   instruction_o  encoded instruction
//   imm_err_o      immediate illegal for the format (qualified by out_valid_o)
//   enc_count_o    results delivered, saturating
//   err_count_o    delivered results with imm_err_o=1, saturating
// ---------------------------------------------------------------------------
module immediate_encoder #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          base_instr_i,
  input  logic [31:0]          immediate_i,
  input  logic [2:0]           ImmSel_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          instruction_o,
  output logic                 imm_err_o,
  output logic [CNT_WIDTH-1:0] enc_count_o,
  output logic [CNT_WIDTH-1:0] err_count_o
);

  localparam logic [2:0] IMM_ITYPE = 3'd0;
  localparam logic [2:0] IMM_STYPE = 3'd1;
  localparam logic [2:0] IMM_BTYPE = 3'd2;
  localparam logic [2:0] IMM_UTYPE = 3'd3;
  localparam logic [2:0] IMM_JTYPE = 3'd4;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // True when bits [31:lsb] of v are all equal, i.e. v is representable as a
  // signed value of (lsb+1) bits. lsb is always a constant at the call site.
  function automatic logic sext_ok(input logic [31:0] v, input int lsb);
    logic [31:0] sh;
    sh = $signed(v) >>> lsb;
    return (sh == 32'hFFFF_FFFF) || (sh == 32'h0000_0000);
  endfunction

  // Stage 1 registers
  logic        s1_valid_r;
  logic [31:0] s1_base_r;
  logic [31:0] s1_imm_r;
  logic [2:0]  s1_sel_r;

  // Stage 2 registers (drive the outputs directly)
  logic        s2_valid_r;
  logic [31:0] s2_instr_r;
  logic        s2_err_r;

  logic [CNT_WIDTH-1:0] enc_cnt_r;
  logic [CNT_WIDTH-1:0] err_cnt_r;

  logic        s1_en_s;
  logic        s2_en_s;
  logic        fire_s;
  logic [31:0] enc_instr_s;
  logic        enc_err_s;

  // Pipeline advance: a stage may load when it is empty or its successor moves.
  always_comb begin
    s2_en_s = !s2_valid_r || out_ready_i;
    s1_en_s = !s1_valid_r || s2_en_s;
    fire_s  = s2_valid_r && out_ready_i;
  end

  // Encode the stage-1 request and check the immediate against the format.
  always_comb begin
    enc_instr_s = s1_base_r;
    enc_err_s   = 1'b0;
    case (s1_sel_r)
      IMM_ITYPE: begin
        enc_instr_s[31:20] = s1_imm_r[11:0];
        enc_err_s          = !sext_ok(s1_imm_r, 11);
      end
      IMM_STYPE: begin
        enc_instr_s[31:25] = s1_imm_r[11:5];
        enc_instr_s[11:7]  = s1_imm_r[4:0];
        enc_err_s          = !sext_ok(s1_imm_r, 11);
      end
      IMM_BTYPE: begin
        enc_instr_s[31]    = s1_imm_r[12];
        enc_instr_s[7]     = s1_imm_r[11];
        enc_instr_s[30:25] = s1_imm_r[10:5];
        enc_instr_s[11:8]  = s1_imm_r[4:1];
        enc_err_s          = !sext_ok(s1_imm_r, 12) || s1_imm_r[0];
      end
      IMM_UTYPE: begin
        enc_instr_s[31:12] = s1_imm_r[31:12];
        enc_err_s          = (s1_imm_r[11:0] != 12'h000);
      end
      IMM_JTYPE: begin
        enc_instr_s[31]    = s1_imm_r[20];
        enc_instr_s[30:21] = s1_imm_r[10:1];
        enc_instr_s[20]    = s1_imm_r[11];
        enc_instr_s[19:12] = s1_imm_r[19:12];
        enc_err_s          = !sext_ok(s1_imm_r, 20) || s1_imm_r[0];
      end
      default: begin
        // Unknown format: pass the base word through untouched and flag it.
        enc_instr_s = s1_base_r;
        enc_err_s   = 1'b1;
      end
    endcase
  end

  // Stage 1: capture the accepted request.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_r <= 1'b0;
      s1_base_r  <= 32'h0000_0000;
      s1_imm_r   <= 32'h0000_0000;
      s1_sel_r   <= 3'd0;
    end else if (s1_en_s) begin
      s1_valid_r <= in_valid_i;
      if (in_valid_i) begin
        s1_base_r <= base_instr_i;
        s1_imm_r  <= immediate_i;
        s1_sel_r  <= ImmSel_i;
      end
    end
  end

  // Stage 2: hold the encoded word and error bit until the consumer takes it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_valid_r <= 1'b0;
      s2_instr_r <= 32'h0000_0000;
      s2_err_r   <= 1'b0;
    end else if (s2_en_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_instr_r <= enc_instr_s;
        s2_err_r   <= enc_err_s;
      end
    end
  end

  // Saturating statistics counters, stepped on each delivered result.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      enc_cnt_r <= {CNT_WIDTH{1'b0}};
      err_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (fire_s) begin
      if (enc_cnt_r != CNT_MAX) begin
        enc_cnt_r <= enc_cnt_r + CNT_ONE;
      end
      if (s2_err_r && (err_cnt_r != CNT_MAX)) begin
        err_cnt_r <= err_cnt_r + CNT_ONE;
      end
    end
  end

  assign in_ready_o    = s1_en_s;
  assign out_valid_o   = s2_valid_r;
  assign instruction_o = s2_instr_r;
  assign imm_err_o     = s2_err_r;
  assign enc_count_o   = enc_cnt_r;
  assign err_count_o   = err_cnt_r;

endmodule
